// File: rtl/decode_stage.sv
// MIPS-subset decode stage: valid/ready in, registered control bundle out.
// Define DECODE_STAGE_SCOREBOARD_EN to build the load-use scoreboard and hazard stall.
module decode_stage #(
  parameter int SB_DEPTH = 1,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      wreg,
  output logic [3:0]      alu_ctrl,
  output logic [31:0]     imm32,
  output logic [4:0]      shamt,
  output logic [25:0]     jimm,
  output logic [1:0]      pc_src,
  output logic            bne,
  output logic            gpr_we,
  output logic            alu_b_src,
  output logic            dram_we,
  output logic            dram_re,
  output logic [1:0]      wb_src,
  output logic            illegal
);

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_wreg;
  logic [3:0]  w_alu_ctrl;
  logic [31:0] w_imm32;
  logic [1:0]  w_pc_src, w_wb_src;
  logic        w_bne, w_gpr_we, w_alu_b_src, w_dram_we, w_dram_re, w_illegal;
  logic        w_use_rs, w_use_rt;
  logic        w_adv, w_hazard, w_accept;

  logic            r_out_valid;
  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_rs, r_rt, r_wreg, r_shamt;
  logic [3:0]      r_alu_ctrl;
  logic [31:0]     r_imm32;
  logic [25:0]     r_jimm;
  logic [1:0]      r_pc_src, r_wb_src;
  logic            r_bne, r_gpr_we, r_alu_b_src, r_dram_we, r_dram_re, r_illegal;

  assign w_op    = in_inst[31:26];
  assign w_funct = in_inst[5:0];
  assign w_rs    = in_inst[25:21];
  assign w_rt    = in_inst[20:16];

  always_comb begin
    w_wreg      = w_rt;
    w_alu_ctrl  = 4'b0000;
    w_imm32     = {{16{in_inst[15]}}, in_inst[15:0]};
    w_pc_src    = 2'b00;
    w_wb_src    = 2'b00;
    w_bne       = 1'b0;
    w_gpr_we    = 1'b1;
    w_alu_b_src = 1'b1;
    w_dram_we   = 1'b0;
    w_dram_re   = 1'b0;
    w_illegal   = 1'b0;
    w_use_rs    = 1'b1;
    w_use_rt    = 1'b0;
    case (w_op)
      6'h00: begin
        w_wreg      = in_inst[15:11];
        w_alu_b_src = 1'b0;
        w_use_rt    = 1'b1;
        case (w_funct)
          6'h20: w_alu_ctrl = 4'b0000;
          6'h21: w_alu_ctrl = 4'b0001;
          6'h22: w_alu_ctrl = 4'b0010;
          6'h23: w_alu_ctrl = 4'b0011;
          6'h24: w_alu_ctrl = 4'b0100;
          6'h25: w_alu_ctrl = 4'b0101;
          6'h26: w_alu_ctrl = 4'b0110;
          6'h27: w_alu_ctrl = 4'b0111;
          6'h2A: w_alu_ctrl = 4'b1010;
          6'h2B: w_alu_ctrl = 4'b1011;
          6'h00: begin w_alu_ctrl = 4'b1100; w_use_rs = 1'b0; end
          6'h02: begin w_alu_ctrl = 4'b1101; w_use_rs = 1'b0; end
          6'h03: begin w_alu_ctrl = 4'b1111; w_use_rs = 1'b0; end
          6'h08: begin w_pc_src = 2'b11; w_gpr_we = 1'b0; end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h02: begin
        w_pc_src = 2'b10; w_gpr_we = 1'b0; w_alu_b_src = 1'b0; w_use_rs = 1'b0;
      end
      6'h03: begin
        w_pc_src = 2'b10; w_wreg = 5'd31; w_wb_src = 2'b10;
        w_alu_b_src = 1'b0; w_use_rs = 1'b0;
      end
      6'h04, 6'h05: begin
        w_pc_src = 2'b01; w_bne = w_op[0]; w_alu_ctrl = 4'b0110;
        w_gpr_we = 1'b0; w_alu_b_src = 1'b0; w_use_rt = 1'b1;
      end
      6'h08: w_alu_ctrl = 4'b0000;
      6'h09: w_alu_ctrl = 4'b0001;
      6'h0A: w_alu_ctrl = 4'b1010;
      6'h0B: w_alu_ctrl = 4'b1011;
      6'h0C: begin w_alu_ctrl = 4'b0100; w_imm32 = {16'h0, in_inst[15:0]}; end
      6'h0D: begin w_alu_ctrl = 4'b0101; w_imm32 = {16'h0, in_inst[15:0]}; end
      6'h0E: begin w_alu_ctrl = 4'b0110; w_imm32 = {16'h0, in_inst[15:0]}; end
      6'h0F: begin
        w_alu_ctrl = 4'b1000; w_imm32 = {in_inst[15:0], 16'h0}; w_use_rs = 1'b0;
      end
      6'h23: begin w_alu_ctrl = 4'b0001; w_dram_re = 1'b1; w_wb_src = 2'b01; end
      6'h2B: begin
        w_alu_ctrl = 4'b0001; w_dram_we = 1'b1; w_gpr_we = 1'b0; w_use_rt = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    // Unknown encodings become a side-effect-free bubble flagged for execute.
    if (w_illegal) begin
      w_gpr_we = 1'b0; w_dram_we = 1'b0; w_dram_re = 1'b0; w_pc_src = 2'b00;
      w_alu_b_src = 1'b0; w_alu_ctrl = 4'b0000; w_wb_src = 2'b00; w_bne = 1'b0;
    end
  end

  assign w_adv    = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

`ifdef DECODE_STAGE_SCOREBOARD_EN
  logic w_out_hit_rs, w_out_hit_rt, w_sb_hit_rs, w_sb_hit_rt;

  assign w_out_hit_rs = r_out_valid & r_dram_re & (r_wreg == w_rs);
  assign w_out_hit_rt = r_out_valid & r_dram_re & (r_wreg == w_rt);

  if (SB_DEPTH > 0) begin : g_sb
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [4:0]          r_sb_reg [SB_DEPTH];
    logic [SB_DEPTH-1:0] w_sb_in_valid;
    logic [4:0]          w_sb_in_reg [SB_DEPTH];
    logic [SB_DEPTH-1:0] w_hit_rs, w_hit_rt;

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_ent
      if (gi == 0) begin : g_head
        assign w_sb_in_valid[gi] = r_out_valid & r_dram_re;
        assign w_sb_in_reg[gi]   = r_wreg;
      end else begin : g_tail
        assign w_sb_in_valid[gi] = r_sb_valid[gi-1];
        assign w_sb_in_reg[gi]   = r_sb_reg[gi-1];
      end
      assign w_hit_rs[gi] = r_sb_valid[gi] & (r_sb_reg[gi] == w_rs);
      assign w_hit_rt[gi] = r_sb_valid[gi] & (r_sb_reg[gi] == w_rt);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sb_valid <= '0;
        for (int i = 0; i < SB_DEPTH; i++) r_sb_reg[i] <= 5'd0;
      end else if (flush) begin
        r_sb_valid <= '0;
      end else if (w_adv) begin
        r_sb_valid <= w_sb_in_valid;
        for (int i = 0; i < SB_DEPTH; i++) r_sb_reg[i] <= w_sb_in_reg[i];
      end
    end

    assign w_sb_hit_rs = |w_hit_rs;
    assign w_sb_hit_rt = |w_hit_rt;
  end else begin : g_nosb
    assign w_sb_hit_rs = 1'b0;
    assign w_sb_hit_rt = 1'b0;
  end

  assign w_hazard = (w_use_rs & (w_rs != 5'd0) & (w_out_hit_rs | w_sb_hit_rs)) |
                    (w_use_rt & (w_rt != 5'd0) & (w_out_hit_rt | w_sb_hit_rt));
  assign in_ready = w_adv & ~w_hazard & ~flush;
`else
  localparam int unused_sb_depth = SB_DEPTH;
  logic w_unused;
  assign w_unused = w_use_rs ^ w_use_rt;
  assign w_hazard = 1'b0;
  assign in_ready = w_adv & ~w_hazard & ~flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0; r_pc <= '0; r_rs <= 5'd0; r_rt <= 5'd0; r_wreg <= 5'd0;
      r_alu_ctrl <= 4'd0; r_imm32 <= 32'd0; r_shamt <= 5'd0; r_jimm <= 26'd0;
      r_pc_src <= 2'd0; r_bne <= 1'b0; r_gpr_we <= 1'b0; r_alu_b_src <= 1'b0;
      r_dram_we <= 1'b0; r_dram_re <= 1'b0; r_wb_src <= 2'd0; r_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1; r_pc <= in_pc; r_rs <= w_rs; r_rt <= w_rt; r_wreg <= w_wreg;
      r_alu_ctrl <= w_alu_ctrl; r_imm32 <= w_imm32; r_shamt <= in_inst[10:6];
      r_jimm <= in_inst[25:0]; r_pc_src <= w_pc_src; r_bne <= w_bne;
      r_gpr_we <= w_gpr_we; r_alu_b_src <= w_alu_b_src; r_dram_we <= w_dram_we;
      r_dram_re <= w_dram_re; r_wb_src <= w_wb_src; r_illegal <= w_illegal;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_pc;
  assign rs        = r_rs;
  assign rt        = r_rt;
  assign wreg      = r_wreg;
  assign alu_ctrl  = r_alu_ctrl;
  assign imm32     = r_imm32;
  assign shamt     = r_shamt;
  assign jimm      = r_jimm;
  assign pc_src    = r_pc_src;
  assign bne       = r_bne;
  assign gpr_we    = r_gpr_we;
  assign alu_b_src = r_alu_b_src;
  assign dram_we   = r_dram_we;
  assign dram_re   = r_dram_re;
  assign wb_src    = r_wb_src;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, queue of expected bundles, negedge monitor.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [4:0]  rs, rt, wreg, shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] imm32;
  logic [25:0] jimm;
  logic [1:0]  pc_src, wb_src;
  logic        bne, gpr_we, alu_b_src, dram_we, dram_re, illegal;

  typedef logic [123:0] bundle_t;
  typedef struct { bundle_t b; int gap; } exp_t;

  exp_t    exp_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      cyc = 0;
  int      last_cyc = 0;
  bundle_t w_act;

`ifdef DECODE_STAGE_SCOREBOARD_EN
  localparam int LU_GAP = 3;
  localparam int LU_STALL = 2;
`else
  localparam int LU_GAP = 1;
  localparam int LU_STALL = 0;
`endif

  decode_stage #(.SB_DEPTH(1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs(rs), .rt(rt), .wreg(wreg), .alu_ctrl(alu_ctrl), .imm32(imm32),
    .shamt(shamt), .jimm(jimm), .pc_src(pc_src), .bne(bne), .gpr_we(gpr_we),
    .alu_b_src(alu_b_src), .dram_we(dram_we), .dram_re(dram_re),
    .wb_src(wb_src), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign w_act = {out_pc, rs, rt, wreg, alu_ctrl, imm32, shamt, jimm, pc_src,
                  bne, gpr_we, alu_b_src, dram_we, dram_re, wb_src, illegal};

  function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] f_rs, f_rt, f_wr,
                                 input logic [3:0] alu, input logic [31:0] imm,
                                 input logic [4:0] sh, input logic [25:0] ji,
                                 input logic [1:0] ps, input logic bn, gw, bs, dw, dr,
                                 input logic [1:0] wb, input logic il);
    return {pc, f_rs, f_rt, f_wr, alu, imm, sh, ji, ps, bn, gw, bs, dw, dr, wb, il};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input bundle_t b,
                      input int gap, input bit push, output int stalls);
    int k;
    if (push) exp_q.push_back('{b, gap});
    in_inst = inst; in_pc = pc; in_valid = 1'b1; stalls = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
    end
    check($sformatf("accept_in_time pc=%h", pc), 128'(k < 20), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("issued pc=%h inst=%h stalls=%0d", pc, inst, stalls);
  endtask

  // Monitor: every bundle taken by execute is compared with the head of the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_bundle: got pc=%h want none", out_pc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bundle pc=%h", out_pc), 128'(w_act), 128'(e.b));
          if (e.gap > 0) check($sformatf("issue_gap pc=%h", out_pc), 128'(cyc - last_cyc), 128'(e.gap));
          $display("bundle pc=%h wreg=%0d alu=%b imm=%h", out_pc, wreg, alu_ctrl, imm32);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    bundle_t lw9_b;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 128'({out_valid, w_act}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // back-to-back
    send(32'h2008FFFF, 32'h100, mk(32'h100, 0, 8, 8, 4'b0000, 32'hFFFFFFFF, 31, 26'h008FFFF,
         2'b00, 0, 1, 1, 0, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'h3409FFFF, 32'h104, mk(32'h104, 0, 9, 9, 4'b0101, 32'h0000FFFF, 31, 26'h009FFFF,
         2'b00, 0, 1, 1, 0, 0, 2'b00, 0), 1, 1'b1, st);
    check("b2b_stalls", 128'(st), 128'(0));

    // load-use
    send(32'h8C880000, 32'h108, mk(32'h108, 4, 8, 8, 4'b0001, 32'h0, 0, 26'h0880000,
         2'b00, 0, 1, 1, 0, 1, 2'b01, 0), 0, 1'b1, st);
    send(32'h01095020, 32'h10C, mk(32'h10C, 8, 9, 10, 4'b0000, 32'h00005020, 0, 26'h1095020,
         2'b00, 0, 1, 0, 0, 0, 2'b00, 0), LU_GAP, 1'b1, st);
    check("loaduse_stalls", 128'(st), 128'(LU_STALL));

    // control ops and assorted classes
    send(32'h0C000010, 32'h110, mk(32'h110, 0, 0, 31, 4'b0000, 32'h10, 0, 26'h0000010,
         2'b10, 0, 1, 0, 0, 0, 2'b10, 0), 0, 1'b1, st);
    send(32'h03E00008, 32'h114, mk(32'h114, 31, 0, 0, 4'b0000, 32'h8, 0, 26'h3E00008,
         2'b11, 0, 0, 0, 0, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'h00031100, 32'h118, mk(32'h118, 0, 3, 2, 4'b1100, 32'h1100, 4, 26'h0031100,
         2'b00, 0, 1, 0, 0, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'hACC50004, 32'h11C, mk(32'h11C, 6, 5, 5, 4'b0001, 32'h4, 0, 26'h0C50004,
         2'b00, 0, 0, 1, 1, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'h1422FFFE, 32'h120, mk(32'h120, 1, 2, 2, 4'b0110, 32'hFFFFFFFE, 31, 26'h022FFFE,
         2'b01, 1, 0, 0, 0, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'h3C071234, 32'h124, mk(32'h124, 0, 7, 7, 4'b1000, 32'h12340000, 8, 26'h0071234,
         2'b00, 0, 1, 1, 0, 0, 2'b00, 0), 0, 1'b1, st);
    send(32'hFC000000, 32'h128, mk(32'h128, 0, 0, 0, 4'b0000, 32'h0, 0, 26'h0,
         2'b00, 0, 0, 0, 0, 0, 2'b00, 1), 0, 1'b1, st);
    send(32'h0000003F, 32'h12C, mk(32'h12C, 0, 0, 0, 4'b0000, 32'h3F, 0, 26'h000003F,
         2'b00, 0, 0, 0, 0, 0, 2'b00, 1), 0, 1'b1, st);

    // backpressure then flush: lw $8 drains, lw $9 is held and killed
    send(32'h8C880000, 32'h140, mk(32'h140, 4, 8, 8, 4'b0001, 32'h0, 0, 26'h0880000,
         2'b00, 0, 1, 1, 0, 1, 2'b01, 0), 0, 1'b1, st);
    lw9_b = mk(32'h144, 4, 9, 9, 4'b0001, 32'h0, 0, 26'h0890000, 2'b00, 0, 1, 1, 0, 1, 2'b01, 0);
    send(32'h8C890000, 32'h144, lw9_b, 0, 1'b0, st);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold_bundle c%0d", i), 128'({out_valid, w_act}), 128'({1'b1, lw9_b}));
      check($sformatf("hold_in_ready c%0d", i), 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    send(32'h01095020, 32'h148, mk(32'h148, 8, 9, 10, 4'b0000, 32'h00005020, 0, 26'h1095020,
         2'b00, 0, 1, 0, 0, 0, 2'b00, 0), 0, 1'b1, st);
    check("post_flush_stalls", 128'(st), 128'(0));
    @(posedge clk); #1;

    // reset while a bundle is stalled
    out_ready = 1'b0;
    send(32'h2008FFFF, 32'h150, mk(32'h150, 0, 8, 8, 4'b0000, 32'hFFFFFFFF, 31, 26'h008FFFF,
         2'b00, 0, 1, 1, 0, 0, 2'b00, 0), 0, 1'b0, st);
    @(negedge clk);
    check("stall_out_valid", 128'(out_valid), 128'(1));
    rst = 1'b1;
    #1;
    check("midrst_outputs", 128'({out_valid, w_act}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the MIPS-subset core. It sits between fetch and execute and accepts one 32-bit instruction per cycle over a valid/ready handshake. It decodes an extended instruction set (shifts, `jr`, `nor`, `sw`/`lw` read/write split, illegal detection) into a registered control bundle. It also holds back consumers of in-flight loads with a load-use scoreboard.

## Interface
- `SB_DEPTH`, default 1: pipeline stages past the output register in which a load's result is still unavailable (range 0..7).
- `PC_W`, default 32: width of the PC carried with the instruction.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: kill the held instruction and clear the scoreboard.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in PC_W: PC of `in_inst`.
- `out_valid` out 1: control bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_pc` out PC_W: PC of the decoded instruction.
- `rs`, `rt` out 5: source register fields.
- `wreg` out 5: resolved destination register (rd, rt or 31).
- `alu_ctrl` out 4: ALU operation.
- `imm32` out 32: immediate, already extended.
- `shamt` out 5: shift amount.
- `jimm` out 26: jump index.
- `pc_src` out 2: next-PC source. 00 = seq, 01 = branch, 10 = jump, 11 = register.
- `bne` out 1: branch sense (1 = bne).
- `gpr_we` out 1: register file write enable.
- `alu_b_src` out 1: ALU B operand select (1 = imm32).
- `dram_we` out 1: data memory write enable.
- `dram_re` out 1: data memory read enable.
- `wb_src` out 2: writeback source. 00 = ALU, 01 = memory, 10 = PC+8.
- `illegal` out 1: unrecognised encoding.

## Operation
- **Supported R-type funct codes:**
  - add 0x20, addu 0x21, sub 0x22, subu 0x23
  - and 0x24, or 0x25, xor 0x26, nor 0x27
  - slt 0x2A, sltu 0x2B
  - sll 0x00, srl 0x02, sra 0x03, jr 0x08
- **Supported opcodes:**
  - j 0x02, jal 0x03, beq 0x04, bne 0x05
  - addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B
  - andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F
  - lw 0x23, sw 0x2B
- **alu_ctrl encoding:**
  - add 0000, addu 0001, sub 0010, subu 0011
  - and 0100, or 0101, xor 0110, nor 0111
  - lui 1000, slt 1010, sltu 1011
  - sll 1100, srl 1101, sra 1111
- **alu_ctrl per instruction class:**
  - Immediate ALU ops use the matching code.
  - lw/sw use 0001.
  - beq/bne use 0110.
  - j/jal/jr use 0000.
- **imm32 extension:**
  - Zero-extended for andi, ori and xori.
  - `{imm16, 16'h0}` for lui.
  - Sign-extended for all other opcodes.
- **wreg:** rd for R-type, 31 for jal, rt otherwise.
- **gpr_we:** 0 for jr, j, beq, bne, sw, and for illegal instructions.
- **Illegal instructions:** `illegal`=1, and `gpr_we`, `dram_we`, `dram_re` are 0. `pc_src` is 00.
- **Source usage:**
  - rs is read by all instructions except j, jal, lui, sll, srl and sra.
  - rt is read by R-type, beq, bne and sw.
  - Register 0 is never a hazard.
- **Scoreboard:**
  - The scoreboard is a shift register of SB_DEPTH entries, each {valid, reg}.
  - `adv = ~out_valid | out_ready`.
  - On adv, entry 0 takes {out_valid & dram_re, wreg} and the remaining entries shift up. The last entry drops.
- **Hazard:** raised when a used source of `in_inst` matches either a valid entry or the output register while that register holds a valid load.
- **Handshake:**
  - `in_ready = adv & ~hazard & ~flush`.
  - The output register loads on `in_valid & in_ready`.
  - Otherwise, on adv, `out_valid` drops to 0 (bubble).
  - Otherwise the output holds stable.
- **Flush** has priority: next cycle `out_valid`=0, all scoreboard entries are invalid, and no input is accepted in the flush cycle.

## Timing
- Decode latency is 1 cycle, from input acceptance to `out_valid`.
- Throughput is 1 instruction per cycle with no hazard.
- The stall for a load followed by a dependent instruction is SB_DEPTH+1 cycles, assuming `out_ready` held high.
- While `out_valid & ~out_ready`, all outputs hold and the scoreboard freezes.
- Reset values: `out_valid`=0, all bundle outputs 0, `out_pc`=0, all scoreboard entries invalid. `in_ready` is 1 after reset.
- Reset asserted mid-stall drops the held instruction immediately. The upstream must re-present it.
- `in_ready` is combinational from `flush`, `out_ready` and `in_inst`.

## Configuration
- `DECODE_STAGE_SCOREBOARD_EN`:
  - Defined: the scoreboard and load-use hazard logic are present as described.
  - Undefined: `hazard` is tied to 0, no scoreboard storage is built, and `in_ready = adv & ~flush`. Execute is then responsible for load-use hazards.

## Test plan
- **Reset:** pulse `rst` mid-stream → `out_valid`=0, all outputs 0, `in_ready`=1 next cycle.
- **Back-to-back decode:** `addi $8,$0,-1` (0x2008FFFF) then `ori $9,$0,0xFFFF` (0x3409FFFF), `out_ready`=1.
  - First bundle: `imm32`=0xFFFFFFFF, `alu_ctrl`=0000.
  - Second bundle: `imm32`=0x0000FFFF, `alu_ctrl`=0101.
  - `wreg`=8 then 9, issued on consecutive cycles.
- **Load-use:** `lw $8,0($4)` (0x8C880000) then `add $10,$8,$9` (0x01095020), SB_DEPTH=1.
  - `in_ready` is low for 2 cycles, and the add issues 3 cycles after the lw.
  - With the macro undefined, the add issues 1 cycle after the lw.
- **Backpressure and flush:** hold `out_ready`=0 for 4 cycles → bundle stable and `in_ready`=0. Then assert `flush` → `out_valid`=0 and the scoreboard is empty next cycle.
- **Control ops:**
  - jal 0x0C000010 → `pc_src`=10, `wreg`=31, `wb_src`=10.
  - jr $31 (0x03E00008) → `pc_src`=11, `gpr_we`=0.
  - Opcode 0x3F → `illegal`=1, all enables 0.
